// File: rtl/ota_seq_pkg.sv
// Shared types and helpers for the OTA/comparator phase sequencer.
// OTA_SEQ_AUTOZERO_EN adds the auto-zero state encodings.
package ota_seq_pkg;

   localparam int unsigned CntW = 4;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StPre      = 3'd1,
      StSettle   = 3'd2,
      StSample   = 3'd3,
      StDecide   = 3'd4
`ifdef OTA_SEQ_AUTOZERO_EN
      ,
      StAzPre    = 3'd5,
      StAzSettle = 3'd6,
      StAzSample = 3'd7
`endif
   } state_e;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Strict majority of nsamp votes.
   function automatic logic majority(input logic [CntW-1:0] ones, input int unsigned nsamp);
      return 32'(ones) > (nsamp / 2);
   endfunction

endpackage

// File: rtl/ota_sync.sv
// N-stage reset-to-0 synchroniser for the asynchronous comparator output.
module ota_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ota_cmp_sequencer.sv
// Precharge/settle/sample sequencer with majority vote over NSAMP comparator samples.
// Optional auto-zero offset capture when OTA_SEQ_AUTOZERO_EN is defined.
module ota_cmp_sequencer
   import ota_seq_pkg::*;
#(
   parameter int unsigned PRE_CYC     = 2,
   parameter int unsigned SETTLE_CYC  = 4,
   parameter int unsigned NSAMP       = 5,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic            cont_i,
   input  logic            abort_i,
   input  logic            ota_out_i,
   output logic            ota_en_o,
   output logic            ota_pre_o,
   output logic            short_o,
   output logic            busy_o,
   output logic            dec_o,
   output logic            dec_valid_o,
   output logic [CntW-1:0] ones_o
);

   localparam int unsigned PhW = $clog2(max2(PRE_CYC, SETTLE_CYC) + 1);
   localparam logic [PhW-1:0]  PreLast    = PhW'(PRE_CYC - 1);
   localparam logic [PhW-1:0]  SettleLast = PhW'(SETTLE_CYC - 1);
   localparam logic [CntW-1:0] SampLast   = CntW'(NSAMP - 1);

   if (SETTLE_CYC <= SYNC_STAGES) begin : g_chk_settle
      $error("SETTLE_CYC must be greater than SYNC_STAGES");
   end
   if ((NSAMP % 2) == 0 || NSAMP < 1 || NSAMP > 15) begin : g_chk_nsamp
      $error("NSAMP must be odd and within 1..15");
   end
   if (PRE_CYC < 1) begin : g_chk_pre
      $error("PRE_CYC must be at least 1");
   end

   logic sync_bit;

   ota_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ota_out_i),
      .q     (sync_bit)
   );

   state_e          state_q, state_d;
   logic [PhW-1:0]  phase_q, phase_d;
   logic [CntW-1:0] samp_q, samp_d;
   logic [CntW-1:0] ones_q, ones_d;
   logic [CntW-1:0] ones_out_q, ones_out_d;
   logic            dec_q, dec_d;
   logic            valid_q, valid_d;
`ifdef OTA_SEQ_AUTOZERO_EN
   logic            off_q, off_d;
`endif

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      samp_d     = samp_q;
      ones_d     = ones_q;
      ones_out_d = ones_out_q;
      dec_d      = dec_q;
      valid_d    = 1'b0;
`ifdef OTA_SEQ_AUTOZERO_EN
      off_d      = off_q;
`endif
      ota_en_o   = 1'b0;
      ota_pre_o  = 1'b0;
      short_o    = 1'b0;

      case (state_q)
         StIdle: begin
            if (start_i && !abort_i) begin
`ifdef OTA_SEQ_AUTOZERO_EN
               state_d = StAzPre;
`else
               state_d = StPre;
`endif
               phase_d = '0;
               samp_d  = '0;
               ones_d  = '0;
            end
         end
         StPre: begin
            ota_pre_o = 1'b1;
            if (phase_q == PreLast) begin
               phase_d = '0;
               state_d = StSettle;
            end else begin
               phase_d = phase_q + PhW'(1);
            end
         end
         StSettle: begin
            ota_en_o = 1'b1;
            if (phase_q == SettleLast) begin
               phase_d = '0;
               state_d = StSample;
            end else begin
               phase_d = phase_q + PhW'(1);
            end
         end
         StSample: begin
            ota_en_o = 1'b1;
            ones_d   = ones_q + CntW'(sync_bit);
            samp_d   = samp_q + CntW'(1);
            state_d  = (samp_q == SampLast) ? StDecide : StPre;
         end
         StDecide: begin
            valid_d    = 1'b1;
`ifdef OTA_SEQ_AUTOZERO_EN
            dec_d      = majority(ones_q, NSAMP) ^ off_q;
`else
            dec_d      = majority(ones_q, NSAMP);
`endif
            ones_out_d = ones_q;
            if (cont_i) begin
               state_d = StPre;
               phase_d = '0;
               samp_d  = '0;
               ones_d  = '0;
            end else begin
               state_d = StIdle;
            end
         end
`ifdef OTA_SEQ_AUTOZERO_EN
         StAzPre: begin
            ota_pre_o = 1'b1;
            short_o   = 1'b1;
            if (phase_q == PreLast) begin
               phase_d = '0;
               state_d = StAzSettle;
            end else begin
               phase_d = phase_q + PhW'(1);
            end
         end
         StAzSettle: begin
            ota_en_o = 1'b1;
            short_o  = 1'b1;
            if (phase_q == SettleLast) begin
               phase_d = '0;
               state_d = StAzSample;
            end else begin
               phase_d = phase_q + PhW'(1);
            end
         end
         StAzSample: begin
            ota_en_o = 1'b1;
            short_o  = 1'b1;
            off_d    = sync_bit;
            state_d  = StPre;
         end
`endif
         default: state_d = StIdle;
      endcase

      // Abort wins over every transition and must not disturb the published result.
      if (abort_i && state_q != StIdle) begin
         state_d    = StIdle;
         phase_d    = '0;
         samp_d     = '0;
         ones_d     = '0;
         valid_d    = 1'b0;
         dec_d      = dec_q;
         ones_out_d = ones_out_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         phase_q    <= '0;
         samp_q     <= '0;
         ones_q     <= '0;
         ones_out_q <= '0;
         dec_q      <= 1'b0;
         valid_q    <= 1'b0;
`ifdef OTA_SEQ_AUTOZERO_EN
         off_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         samp_q     <= samp_d;
         ones_q     <= ones_d;
         ones_out_q <= ones_out_d;
         dec_q      <= dec_d;
         valid_q    <= valid_d;
`ifdef OTA_SEQ_AUTOZERO_EN
         off_q      <= off_d;
`endif
      end
   end

   assign busy_o      = (state_q != StIdle);
   assign dec_o       = dec_q;
   assign dec_valid_o = valid_q;
   assign ones_o      = ones_out_q;

endmodule

// File: tb/tb_ota_cmp_sequencer.sv
// Scoreboard bench: stimulus pushes expected decisions, a negedge monitor checks each valid pulse.
module tb_ota_cmp_sequencer;

   localparam int unsigned PRE  = 2;
   localparam int unsigned SET  = 4;
   localparam int unsigned NS   = 5;
   localparam int unsigned SYNC = 2;
   localparam int          W    = PRE + SET + 1;   // cycles per sample window
   localparam int          CONV = NS * W + 1;      // windows plus the decide cycle

   logic       clk, rst_n, start_i, cont_i, abort_i, ota_out_i;
   logic       ota_en_o, ota_pre_o, short_o, busy_o, dec_o, dec_valid_o;
   logic [3:0] ones_o;

   typedef struct {
      logic dec;
      int   ones;
      int   cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic off_m     = 1'b0;
   logic last_dec  = 1'b0;
   int   last_ones = 0;

   ota_cmp_sequencer #(
      .PRE_CYC     (PRE),
      .SETTLE_CYC  (SET),
      .NSAMP       (NS),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .cont_i      (cont_i),
      .abort_i     (abort_i),
      .ota_out_i   (ota_out_i),
      .ota_en_o    (ota_en_o),
      .ota_pre_o   (ota_pre_o),
      .short_o     (short_o),
      .busy_o      (busy_o),
      .dec_o       (dec_o),
      .dec_valid_o (dec_valid_o),
      .ones_o      (ones_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && dec_valid_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid actual=1 expected=0 (cycle %0d)", cyc);
         end else begin
            e = exp_q.pop_front();
            check("dec_o", int'(dec_o), int'(e.dec));
            check("ones_o", int'(ones_o), e.ones);
            check("valid_cycle", cyc, e.cyc);
         end
      end
   end

   // One accepted start followed by nconv conversions (continuous mode when nconv > 1).
   task automatic run(input int nconv, input bit poke, input bit use_fixed,
                      input logic [14:0] fixed, input bit az_bit);
      int          s;
      int          ones;
      logic [14:0] b;
      exp_t        e;
      @(posedge clk); #1;
      ota_out_i = az_bit;
      start_i   = 1'b1;
      cont_i    = (nconv > 1);
      @(posedge clk); #1;
      start_i = 1'b0;
      check("busy_after_accept", int'(busy_o), 1);
      s = cyc;
`ifdef OTA_SEQ_AUTOZERO_EN
      off_m = az_bit;
      repeat (W) @(posedge clk);
      #1;
      s = cyc;
`endif
      for (int j = 0; j < nconv; j++) begin
         b = (use_fixed && j == 0) ? fixed : 15'($urandom);
         ones = 0;
         for (int k = 0; k < int'(NS); k++) ones += int'(b[k]);
         e.dec  = (ones > int'(NS / 2)) ^ off_m;
         e.ones = ones;
         e.cyc  = s + CONV;
         exp_q.push_back(e);
         last_dec  = e.dec;
         last_ones = ones;
         cont_i = (j < nconv - 1);
         for (int k = 0; k < int'(NS); k++) begin
            ota_out_i = b[k];
            start_i   = poke && (k == 2);
            @(posedge clk); #1;
            start_i = 1'b0;
            repeat (W - 1) @(posedge clk);
            #1;
         end
         @(posedge clk); #1;
         s = cyc;
      end
      check("busy_after_decide", int'(busy_o), 0);
      @(posedge clk); #1;
      check("busy_idle", int'(busy_o), 0);
      check("valid_single_cycle", int'(dec_valid_o), 0);
   endtask

   task automatic abort_test();
      @(posedge clk); #1;
      ota_out_i = 1'($urandom);
      start_i   = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      check("busy_before_abort", int'(busy_o), 1);
      abort_i = 1'b1;
      @(posedge clk); #1;
      abort_i = 1'b0;
      check("abort_busy", int'(busy_o), 0);
      check("abort_en", int'(ota_en_o), 0);
      check("abort_dec_kept", int'(dec_o), int'(last_dec));
      check("abort_ones_kept", int'(ones_o), last_ones);
      repeat (45) @(posedge clk);
      #1;
      abort_i = 1'b1;
      start_i = 1'b1;
      @(posedge clk); #1;
      abort_i = 1'b0;
      start_i = 1'b0;
      check("start_with_abort_idle", int'(busy_o), 0);
   endtask

   task automatic reset_test();
      @(posedge clk); #1;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      check("rst_en", int'(ota_en_o), 0);
      check("rst_pre", int'(ota_pre_o), 0);
      check("rst_short", int'(short_o), 0);
      check("rst_busy", int'(busy_o), 0);
      check("rst_dec", int'(dec_o), 0);
      check("rst_valid", int'(dec_valid_o), 0);
      check("rst_ones", int'(ones_o), 0);
      last_dec  = 1'b0;
      last_ones = 0;
      off_m     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("post_reset_idle", int'(busy_o), 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      start_i   = 1'b0;
      cont_i    = 1'b0;
      abort_i   = 1'b0;
      ota_out_i = 1'b0;
      #3;
      check("reset_busy", int'(busy_o), 0);
      check("reset_dec", int'(dec_o), 0);
      check("reset_ones", int'(ones_o), 0);
      check("reset_en_pre", int'({ota_en_o, ota_pre_o, short_o}), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      run(1, 1'b0, 1'b1, 15'h001F, 1'b0);   // all ones
      run(1, 1'b0, 1'b1, 15'h001F, 1'b1);   // all ones, offset sample high
      run(1, 1'b0, 1'b1, 15'h0005, 1'b0);   // 1,0,1,0,0
      run(1, 1'b0, 1'b1, 15'h000B, 1'b1);   // 1,1,0,1,0
      abort_test();
      reset_test();
      run(1, 1'b0, 1'b1, 15'h001F, 1'b0);
      run(3, 1'b1, 1'b1, 15'h001F, 1'b0);   // continuous, start poked while busy
      for (int r = 0; r < 4; r++) begin
         run(1 + int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0, 15'h0,
             1'($urandom_range(0, 1)));
      end

      repeat (10) @(posedge clk);
      #1;
      check("missing_valid", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
